// File: rtl/fetch_queue_if.sv
// Fetch-to-decode handshake bundle for fetch_queue.
// master = fetch/decode side, slave = the queue itself.
interface fetch_queue_if #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 32
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_pc;
  logic [DATA_WIDTH-1:0] in_instr;
  logic                  flush;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_pc;
  logic [DATA_WIDTH-1:0] out_instr;
  logic [CNT_W-1:0]      count;
  logic                  full;
  logic                  empty;

  modport master (
    output in_valid, in_pc, in_instr, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_instr, count, full, empty
  );

  modport slave (
    input  in_valid, in_pc, in_instr, flush, out_ready,
    output in_ready, out_valid, out_pc, out_instr, count, full, empty
  );
endinterface

// File: rtl/fetch_queue.sv
// Show-ahead circular buffer of {pc, instr} between fetch and decode.
// Flush (taken branch) drops every entry and overrides any same-cycle push/pop.
module fq_slot #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  // Payload storage is intentionally unreset; occupancy alone defines validity.
  always_ff @(posedge clk)
    if (we) q <= d;
endmodule

module fetch_queue #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  fetch_queue_if.slave q
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] instr;
  } fq_entry_t;

  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [CNT_W-1:0]        count;
  logic                    push, pop;
  logic [DEPTH-1:0]        slot_we;
  fq_entry_t               wr_data;
  fq_entry_t [DEPTH-1:0]   slot_q;
  fq_entry_t               head;

  assign q.full     = (count == CNT_W'(DEPTH));
  assign q.empty    = (count == '0);
  assign q.in_ready = ~q.full;
  assign q.out_valid = ~q.empty;
  assign q.count    = count;

  assign push = q.in_valid  && q.in_ready  && !q.flush;
  assign pop  = q.out_valid && q.out_ready && !q.flush;

  assign wr_data = '{pc: q.in_pc, instr: q.in_instr};
  assign slot_we = push ? (DEPTH'(1) << wr_ptr) : '0;

  genvar i;
  generate
    for (i = 0; i < DEPTH; i++) begin : g_slot
      fq_slot #(.W($bits(fq_entry_t))) u_slot (
        .clk (clk),
        .we  (slot_we[i]),
        .d   (wr_data),
        .q   (slot_q[i])
      );
    end
  endgenerate

  assign head        = slot_q[rd_ptr];
  assign q.out_pc    = q.out_valid ? head.pc    : '0;
  assign q.out_instr = q.out_valid ? head.instr : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (q.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Decoupling buffer directly downstream of the program counter and instruction ROM. Captures {PC, instruction} pairs from fetch and presents them in order to decode over a valid/ready handshake.
- Absorbs decode stalls without losing fetched words.
- Discards all buffered entries on a control-flow redirect (taken branch, PCsrc=1) so wrong-path instructions never reach decode.

Parameters:
- DEPTH, 4, number of entries; power of two, at least 2
- DATA_WIDTH, 32, width of PC and instruction fields (DATA_BUS width)
- CNT_W, $clog2(DEPTH)+1, width of the occupancy counter (derived; not overridden)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  asynchronous, active-low reset; rst=0 clears all state immediately
- in_valid  input  1  fetch presents a valid {in_pc, in_instr} this cycle
- in_ready  output  1  queue accepts a push this cycle
- in_pc  input  DATA_WIDTH  PC of fetched instruction
- in_instr  input  DATA_WIDTH  fetched instruction word
- flush  input  1  redirect; discard every entry (driven from taken-branch PCsrc)
- out_valid  output  1  head entry is valid
- out_ready  input  1  decode consumes the head entry this cycle
- out_pc  output  DATA_WIDTH  PC of head entry
- out_instr  output  DATA_WIDTH  instruction of head entry
- count  output  CNT_W  current occupancy, 0..DEPTH
- full  output  1  count == DEPTH
- empty  output  1  count == 0

Behaviour:
- Storage: circular buffer of DEPTH entries, each {pc, instr}. Write pointer wr_ptr and read pointer rd_ptr are each log2(DEPTH) bits and wrap modulo DEPTH. A registered count tracks occupancy.
- Reset (rst=0, asynchronous): wr_ptr=0, rd_ptr=0, count=0. Outputs: out_valid=0, out_pc=0, out_instr=0, full=0, empty=1, in_ready=1. Storage array is not reset.
- in_ready = !full, combinational from count. There is no dependence on out_ready, so there is no combinational path from out_ready to in_ready.
- push = in_valid && in_ready && !flush. On push, {in_pc, in_instr} is written at wr_ptr, then wr_ptr+1.
- pop = out_valid && out_ready && !flush. On pop, rd_ptr+1.
- count update:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged
  - neither: unchanged
- Show-ahead output:
  - out_valid = (count != 0).
  - out_pc/out_instr = storage[rd_ptr] when out_valid, else 0. These are driven combinationally from the registered pointer and array.
- Latency: a word pushed into an empty queue at edge N appears on out_* with out_valid=1 after edge N. There is no same-cycle bypass from in_* to out_*.
- flush=1 at an edge: wr_ptr=0, rd_ptr=0, count=0. Any push or pop in that cycle is ignored, even if the handshake signals are high. After that edge, out_valid=0 and empty=1. A single flush cycle suffices.
- Full: in_ready=0 and in_valid is ignored. Fetch holds its PC until in_ready returns; that stall is the fetch stage's responsibility.
- Empty: out_valid=0, and out_ready is ignored (no underflow; count never goes negative).
- Wrap-around: the pointers roll from DEPTH-1 to 0 with no gap. Order is preserved across the wrap.
- Reset mid-operation: all entries are lost and outputs return to their reset values without waiting for clk. Normal operation resumes on the first rising edge after rst returns to 1.
- full = (count == DEPTH) and empty = (count == 0), both derived combinationally from count.

Test Plan:
- Reset then push 3 entries (pc 0x0,0x4,0x8; instr 0x00A00093,0x00100113,0x002081B3) with out_ready=0 -> count=3; out_valid=1; out_pc=0x0, out_instr=0x00A00093 held stable.
- Fill to DEPTH=4 with out_ready=0 -> full=1, in_ready=0; a fifth push (pc 0x10) is ignored; draining then yields pc 0x0,0x4,0x8,0xC in order, after which empty=1.
- Continuous streaming (in_valid=1, out_ready=1) for 10 words, pc 0x0..0x24 -> after first fill, count stays 1; out_pc increments by 4 each cycle; pointers wrap twice with no loss or duplication.
- Two entries queued, then flush=1 in the same cycle as in_valid=1 (pc 0x40) and out_ready=1 -> next cycle count=0, out_valid=0; 0x40 is not stored; the next push (pc 0x100) is the first word out.
- Pop from empty (out_ready=1, in_valid=0) for 3 cycles -> count stays 0, out_valid=0, out_pc=0.
- Assert rst=0 between clock edges with count=3 -> count=0, out_valid=0, empty=1 immediately, before the next edge; after release, pushing pc 0x200 gives out_pc=0x200 one edge later.
